step_ctrl: RTL and testbench
============================

Name: step_ctrl

Overview:
- Consumes the one-cycle db_tick pulses from the debouncers on the board buttons and turns them into a registered, one-cycle clock-enable (cpu_en) for the single-cycle MIPS core under board test.
- Supports three modes: single step, free run at a divided rate, and a burst of N steps.
- Counts the steps issued and honours a halt request from the core.

Parameters:
- DIV_W, 24, run/burst rate divider width; one cpu_en every 2^DIV_W clocks (2^24 x 20 ns ≈ 335 ms).
- CNT_W, 16, width of the issued-step counter.
- BURST_W, 8, width of the burst length input.

Ports:
- clk  input  1  system clock (50 MHz on board).
- reset  input  1  asynchronous, active-high reset.
- step_tick  input  1  debounced one-cycle pulse, step button.
- run_tick  input  1  debounced one-cycle pulse, run/stop toggle button.
- burst_tick  input  1  debounced one-cycle pulse, burst button.
- burst_len  input  BURST_W  number of steps per burst; sampled on the accepted burst_tick.
- halt_req  input  1  level from the core; high = core halted.
- cpu_en  output  1  registered one-cycle enable to the core.
- running  output  1  high in RUN or BURST.
- busy_burst  output  1  high in BURST only.
- step_cnt  output  CNT_W  count of cpu_en pulses issued.

Behaviour:
- Reset: asynchronous, active-high.
  - Applies immediately, including mid-burst or mid-run.
  - Resets the FSM to IDLE, div=0, remain=0, cpu_en=0, running=0, busy_burst=0, step_cnt=0.
- FSM states are IDLE, RUN, BURST. All outputs are registered.
- Input priority for events in the same cycle: halt_req > run_tick > burst_tick > step_tick.
- IDLE:
  - step_tick with halt_req=0: cpu_en=1 in the next cycle, for exactly 1 cycle.
  - run_tick: go to RUN, clear div.
  - burst_tick with burst_len!=0: go to BURST, clear div, load remain=burst_len.
  - burst_tick with burst_len==0: ignored; stay in IDLE with no pulse.
- RUN:
  - div increments every clock.
  - When div==all-ones, cpu_en=1 in the next cycle and div wraps to 0.
  - The first pulse therefore arrives 2^DIV_W clocks after the entry cycle.
  - run_tick returns to IDLE; any pulse already scheduled for the next cycle is suppressed.
  - step_tick and burst_tick are ignored in RUN.
- BURST:
  - Same divider timing as RUN.
  - Each terminal count issues cpu_en and decrements remain.
  - The pulse issued with remain==1 is the last one; the FSM returns to IDLE in the same transition.
  - run_tick aborts to IDLE with no further pulses.
  - step_tick and burst_tick are ignored in BURST.
- halt_req:
  - While high, no cpu_en is issued in any state.
  - RUN and BURST exit to IDLE on the first cycle halt_req is seen high.
  - Exit is to IDLE, not to RUN, when halt deasserts.
- step_cnt:
  - Increments in the same cycle cpu_en is high.
  - Width CNT_W; wraps from all-ones to 0 silently.
- Back-to-back step_tick pulses on consecutive cycles produce consecutive cpu_en pulses, one per tick, with no loss.
- cpu_en is never high for 2 consecutive cycles in RUN/BURST (DIV_W >= 1 required).

Test Plan (DIV_W=3, CNT_W=4, BURST_W=8):
- Single step: reset, then step_tick at cycle 10 -> cpu_en high only in cycle 11; step_cnt=1 from cycle 11; running=0 throughout.
- Run mode: run_tick at cycle 0 -> running=1; cpu_en pulses at cycles 9, 17, 25 (every 8 clocks).
  - run_tick at cycle 20 -> no pulse at 25; running=0 at 21.
- Burst: burst_len=3, burst_tick at cycle 0 -> exactly 3 cpu_en pulses, 8 clocks apart; busy_burst falls with the 3rd pulse; step_cnt=3.
  - burst_len=0 -> no pulses, state stays IDLE.
- Halt and priority:
  - In RUN, raise halt_req -> no further cpu_en; running=0 next cycle; stays IDLE after halt drops.
  - step_tick while halt_req=1 -> no pulse.
  - step_tick and run_tick in the same cycle -> RUN entered, no step pulse.
- Wrap and reset:
  - 17 step_ticks -> step_cnt=1 (wrapped).
  - Assert reset mid-burst (remain=2) -> all outputs 0 immediately (asynchronous); no pulses after release until a new tick arrives.

Source files
------------

// File: rtl/step_ctrl.sv
// ---------------------------------------------------------------------------
// step_ctrl
//   Turns debounced button pulses into a one-cycle clock enable for a
//   single-cycle MIPS core on the bench board. Three modes:
//     IDLE  - a step_tick issues one cpu_en on the following cycle
//     RUN   - one cpu_en every 2^DIV_W clocks until run_tick or halt
//     BURST - burst_len enables at the RUN rate, then back to IDLE
//   The enables issued are counted in step_cnt, which wraps silently.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   step_tick   one-cycle pulse, step button
//   run_tick    one-cycle pulse, run/stop toggle
//   burst_tick  one-cycle pulse, burst button
//   burst_len   steps per burst, sampled on an accepted burst_tick
//   halt_req    level from the core, high = halted
//   cpu_en      registered one-cycle enable to the core
//   running     high in RUN or BURST
//   busy_burst  high in BURST only
//   step_cnt    number of cpu_en pulses issued
// ---------------------------------------------------------------------------
module step_ctrl #(
  parameter int DIV_W   = 24,
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step_tick,
  input  logic               run_tick,
  input  logic               burst_tick,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               halt_req,
  output logic               cpu_en,
  output logic               running,
  output logic               busy_burst,
  output logic [CNT_W-1:0]   step_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BURST_W-1:0] remain_q, remain_d;
  logic               cpu_en_q, cpu_en_d;
  logic               running_q, running_d;
  logic               busy_burst_q, busy_burst_d;
  logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;
  logic               div_tc;

  // Terminal count of the rate divider: the next cycle carries an enable.
  assign div_tc = (div_q == {DIV_W{1'b1}});

  // Next-state, divider, burst counter and registered-output computation.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    remain_d = remain_q;
    cpu_en_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Divider is held at zero so RUN/BURST always start a full period.
        div_d = {DIV_W{1'b0}};
        if (halt_req) begin
          state_d = ST_IDLE;
        end else if (run_tick) begin
          state_d = ST_RUN;
        end else if (burst_tick && (burst_len != {BURST_W{1'b0}})) begin
          state_d  = ST_BURST;
          remain_d = burst_len;
        end else if (step_tick) begin
          cpu_en_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        div_d = div_q + DIV_W'(1);
        if (halt_req || run_tick) begin
          // Leaving suppresses an enable that would land next cycle.
          state_d = ST_IDLE;
          div_d   = {DIV_W{1'b0}};
        end else begin
          cpu_en_d = div_tc;
        end
      end

      ST_BURST: begin
        div_d = div_q + DIV_W'(1);
        if (halt_req || run_tick) begin
          state_d  = ST_IDLE;
          div_d    = {DIV_W{1'b0}};
          remain_d = {BURST_W{1'b0}};
        end else if (div_tc) begin
          cpu_en_d = 1'b1;
          remain_d = remain_q - BURST_W'(1);
          // The enable issued with one step left is the final one.
          if (remain_q == BURST_W'(1)) begin
            state_d = ST_IDLE;
            div_d   = {DIV_W{1'b0}};
          end else begin
            state_d = ST_BURST;
          end
        end else begin
          state_d = ST_BURST;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        div_d    = {DIV_W{1'b0}};
        remain_d = {BURST_W{1'b0}};
      end
    endcase

    // Status outputs reflect the state being entered, so they are
    // registered yet line up with the cycle the state is active.
    running_d    = (state_d != ST_IDLE);
    busy_burst_d = (state_d == ST_BURST);
    step_cnt_d   = step_cnt_q + {{(CNT_W-1){1'b0}}, cpu_en_d};
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      div_q        <= {DIV_W{1'b0}};
      remain_q     <= {BURST_W{1'b0}};
      cpu_en_q     <= 1'b0;
      running_q    <= 1'b0;
      busy_burst_q <= 1'b0;
      step_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      remain_q     <= remain_d;
      cpu_en_q     <= cpu_en_d;
      running_q    <= running_d;
      busy_burst_q <= busy_burst_d;
      step_cnt_q   <= step_cnt_d;
    end
  end

  assign cpu_en     = cpu_en_q;
  assign running    = running_q;
  assign busy_burst = busy_burst_q;
  assign step_cnt   = step_cnt_q;

endmodule

// File: tb/tb_step_ctrl.sv
// ---------------------------------------------------------------------------
// tb_step_ctrl
//   Self-checking bench for step_ctrl with DIV_W=3, CNT_W=4, BURST_W=8.
//   A cycle-numbered behavioural model (enables fall on multiples of the
//   period after the entry cycle) is compared with the DUT every cycle;
//   directed scenarios pin the model with hand-computed pulse positions.
// ---------------------------------------------------------------------------
module tb_step_ctrl;

  localparam int DIV_W   = 3;
  localparam int CNT_W   = 4;
  localparam int BURST_W = 8;
  localparam int PER     = 8;   // 2^DIV_W
  localparam int CMOD    = 16;  // 2^CNT_W

  logic               clk;
  logic               reset;
  logic               step_tick;
  logic               run_tick;
  logic               burst_tick;
  logic [BURST_W-1:0] burst_len;
  logic               halt_req;
  logic               cpu_en;
  logic               running;
  logic               busy_burst;
  logic [CNT_W-1:0]   step_cnt;

  step_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .step_tick  (step_tick),
    .run_tick   (run_tick),
    .burst_tick (burst_tick),
    .burst_len  (burst_len),
    .halt_req   (halt_req),
    .cpu_en     (cpu_en),
    .running    (running),
    .busy_burst (busy_burst),
    .step_cnt   (step_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 run, 2 burst. In run/burst an enable appears in every
  // cycle c with (c - entry) a positive multiple of PER.
  int   cyc     = 0;
  int   m_mode  = 0;
  int   m_entry = 0;
  int   m_left  = 0;
  logic m_en    = 1'b0;
  int   m_cnt   = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0;
      m_left = 0;
      m_en   = 1'b0;
      m_cnt  = 0;
    end else begin
      m_en = 1'b0;
      if (m_mode == 0) begin
        if (halt_req) begin
          m_mode = 0;
        end else if (run_tick) begin
          m_mode  = 1;
          m_entry = cyc + 1;
        end else if (burst_tick && burst_len != 0) begin
          m_mode  = 2;
          m_entry = cyc + 1;
          m_left  = int'(burst_len);
        end else if (step_tick) begin
          m_en = 1'b1;
        end
      end else begin
        if (halt_req || run_tick) begin
          m_mode = 0;
        end else if (((cyc + 1 - m_entry) % PER) == 0) begin
          m_en = 1'b1;
          if (m_mode == 2) begin
            m_left--;
            if (m_left == 0) m_mode = 0;
          end
        end
      end
      m_cnt = (m_cnt + int'(m_en)) % CMOD;
    end
    cyc++;
    #1;
    chk("model_cpu_en",     64'(cpu_en),     64'(m_en));
    chk("model_running",    64'(running),    64'(m_mode != 0));
    chk("model_busy_burst", 64'(busy_burst), 64'(m_mode == 2));
    chk("model_step_cnt",   64'(step_cnt),   64'(m_cnt));
  end

  // ---------------- directed helpers ----------------
  logic [63:0] seen;
  logic [63:0] run_log;
  logic [63:0] busy_log;
  int          cnt_log [64];

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Observe cycles 1..n after a tick placed in cycle 0; optional run_tick
  // in cycle stop_at.
  task automatic watch(input int n, input int stop_at);
    seen     = '0;
    run_log  = '0;
    busy_log = '0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      step_tick  = 1'b0;
      run_tick   = 1'b0;
      burst_tick = 1'b0;
      seen[k]     = cpu_en;
      run_log[k]  = running;
      busy_log[k] = busy_burst;
      cnt_log[k]  = int'(step_cnt);
      if (k == stop_at) run_tick = 1'b1;
    end
  endtask

  int cnt0;
  int pulses;

  initial begin
    reset      = 1'b1;
    step_tick  = 1'b0;
    run_tick   = 1'b0;
    burst_tick = 1'b0;
    burst_len  = 8'd0;
    halt_req   = 1'b0;

    // Reset state
    #1;
    chk("reset_cpu_en",   64'(cpu_en),     64'd0);
    chk("reset_running",  64'(running),    64'd0);
    chk("reset_busy",     64'(busy_burst), 64'd0);
    chk("reset_step_cnt", 64'(step_cnt),   64'd0);
    nclk(3);
    reset = 1'b0;

    // Single step at cycle 10 after reset
    nclk(10);
    cnt0 = int'(step_cnt);
    step_tick = 1'b1;
    watch(5, 0);
    chk("step_pulse_mask", seen, 64'h2);
    chk("step_cnt_after", 64'(cnt_log[1]), 64'((cnt0 + 1) % CMOD));
    chk("step_running", run_log, 64'd0);

    // Run mode, stopped by run_tick in cycle 20
    @(negedge clk);
    run_tick = 1'b1;
    watch(27, 20);
    chk("run_pulse_mask", seen, 64'h0000_0000_0002_0200);
    chk("run_running_1", 64'(run_log[1]), 64'd1);
    chk("run_running_20", 64'(run_log[20]), 64'd1);
    chk("run_running_21", 64'(run_log[21]), 64'd0);

    // Burst of 3
    @(negedge clk);
    cnt0 = int'(step_cnt);
    burst_len  = 8'd3;
    burst_tick = 1'b1;
    watch(32, 0);
    chk("burst_pulse_mask", seen, 64'h0000_0000_0202_0200);
    chk("burst_busy_24", 64'(busy_log[24]), 64'd1);
    chk("burst_busy_25", 64'(busy_log[25]), 64'd0);
    chk("burst_cnt_delta", 64'((cnt_log[32] - cnt0 + CMOD) % CMOD), 64'd3);

    // Burst of length 0 is ignored
    @(negedge clk);
    burst_len  = 8'd0;
    burst_tick = 1'b1;
    watch(12, 0);
    chk("burst0_pulses", seen, 64'd0);
    chk("burst0_running", run_log, 64'd0);

    // Halt in RUN
    @(negedge clk);
    run_tick = 1'b1;
    watch(4, 0);
    chk("halt_run_entered", 64'(run_log[4]), 64'd1);
    @(negedge clk);
    halt_req = 1'b1;
    @(negedge clk);
    chk("halt_running_next", 64'(running), 64'd0);
    nclk(5);
    halt_req = 1'b0;
    watch(30, 0);
    chk("halt_no_pulses", seen, 64'd0);
    chk("halt_stays_idle", run_log, 64'd0);

    // step_tick while halted
    @(negedge clk);
    halt_req  = 1'b1;
    step_tick = 1'b1;
    watch(4, 0);
    chk("halt_step_blocked", seen, 64'd0);
    halt_req = 1'b0;

    // step_tick and run_tick together: RUN wins
    @(negedge clk);
    step_tick = 1'b1;
    run_tick  = 1'b1;
    watch(3, 0);
    chk("prio_no_step", seen, 64'd0);
    chk("prio_running", 64'(run_log[1]), 64'd1);
    @(negedge clk);
    run_tick = 1'b1;
    watch(2, 0);
    chk("prio_stopped", 64'(run_log[1]), 64'd0);

    // 17 back-to-back steps from a fresh reset wrap to 1
    @(negedge clk);
    reset = 1'b1;
    nclk(2);
    reset = 1'b0;
    @(negedge clk);
    pulses    = 0;
    step_tick = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 17) step_tick = 1'b0;
      pulses += int'(cpu_en);
    end
    chk("wrap_pulses", 64'(pulses), 64'd17);
    chk("wrap_step_cnt", 64'(step_cnt), 64'd1);

    // Reset mid-burst with two steps remaining
    @(negedge clk);
    burst_len  = 8'd3;
    burst_tick = 1'b1;
    watch(8, 0);
    @(negedge clk);
    chk("midburst_first_pulse", 64'(cpu_en), 64'd1);
    reset = 1'b1;
    #1;
    chk("async_cpu_en",   64'(cpu_en),     64'd0);
    chk("async_running",  64'(running),    64'd0);
    chk("async_busy",     64'(busy_burst), 64'd0);
    chk("async_step_cnt", 64'(step_cnt),   64'd0);
    nclk(2);
    reset = 1'b0;
    watch(30, 0);
    chk("post_reset_quiet", seen, 64'd0);
    chk("post_reset_idle", run_log, 64'd0);

    // Randomized phase, checked every cycle by the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset      = ($urandom_range(0, 799) == 0);
      step_tick  = ($urandom_range(0, 7) == 0);
      run_tick   = ($urandom_range(0, 39) == 0);
      burst_tick = ($urandom_range(0, 14) == 0);
      burst_len  = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 59) == 0) halt_req = ~halt_req;
    end
    @(negedge clk);
    reset      = 1'b0;
    step_tick  = 1'b0;
    run_tick   = 1'b0;
    burst_tick = 1'b0;
    halt_req   = 1'b0;
    nclk(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
